ex_mem_buffer: RTL and testbench
================================

// Module: ex_mem_buffer
// PURPOSE
//   EX->MEM pipeline buffer: a small FIFO directly downstream of the ALU/FPU stage.
//   - Captures each completed EX result (ALU/FPU value, branch flag, destination, memory controls, store data).
//   - Presents results in order to the MEM stage.
//   - Back-pressures EX when full, so long FPU ops and slow memory overlap without dropping results.
// PARAMETERS
//   XLEN   32  data width of result and store-data fields
//   DEPTH  2   number of entries; power of two, >=2
// PORTS
//   clk             in   1     system clock, rising edge
//   rstn            in   1     asynchronous active-low reset
//   ex_valid        in   1     EX holds an instruction this cycle
//   alu_ready       in   1     ALU/FPU result is final (alu_ready from the ALU)
//   alu_result_ex   in   XLEN  ALU/FPU result
//   branch_alu      in   1     ALU zero flag (branch condition)
//   write_data_ex   in   XLEN  store data (rs2 after forwarding)
//   rd_ex           in   5     destination register index
//   reg_write_ex    in   1     instruction writes the register file
//   mem_read_ex     in   1     load
//   mem_write_ex    in   1     store
//   flush           in   1     discard all buffered entries (branch mispredict / redirect)
//   data_ready_mem  in   1     MEM stage consumes the head entry this cycle
//   ex_stall        out  1     EX must hold its instruction this cycle
//   mem_valid       out  1     head entry valid
//   alu_result_mem  out  XLEN  head result
//   branch_mem      out  1     head branch flag
//   write_data_mem  out  XLEN  head store data
//   rd_mem          out  5     head destination
//   reg_write_mem   out  1     head reg-write (forced 0 when !mem_valid)
//   mem_read_mem    out  1     head load (forced 0 when !mem_valid)
//   mem_write_mem   out  1     head store (forced 0 when !mem_valid)
//   count           out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//   - Storage: circular array of DEPTH entries, each {result, branch, wdata, rd, rw, mr, mw}.
//   - Pointers wr_ptr/rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
//   - Separate count register, 0..DEPTH.
//   - push = ex_valid & alu_ready & (count != DEPTH) & ~flush.
//     - Decision does NOT depend on data_ready_mem: no combinational path MEM->EX.
//   - pop = mem_valid & data_ready_mem & ~flush.
//   - ex_stall = ex_valid & (~alu_ready | (count == DEPTH) | flush). Combinational.
//   - mem_valid = (count != 0). Head outputs are driven combinationally from entry[rd_ptr].
//   - Latency: a push at edge N makes the entry visible on the head outputs after edge N
//     (1 cycle when the buffer is empty).
//   - Push and pop in the same cycle: both pointers advance; count unchanged.
//     - Legal at count==1 and at intermediate counts.
//     - At count==DEPTH a push is refused even if a pop occurs.
//   - Ordering: entries leave in the order they were pushed; fields are never mixed between entries.
//   - flush: on the next edge, count/wr_ptr/rd_ptr <- 0.
//     - Overrides a simultaneous push and pop: nothing is written, nothing is counted as consumed.
//   - Reset (async, rstn=0): count, wr_ptr, rd_ptr <- 0.
//     - mem_valid, reg_write_mem, mem_read_mem and mem_write_mem are 0 immediately.
//     - Data outputs are don't-care. Entry storage is not reset.
//   - Reset asserted mid-operation: all buffered entries are lost; no partial state remains after release.
//   - Control outputs (rw/mr/mw) are qualified by mem_valid, so an empty buffer never triggers writes or stores.
//   - No state machine beyond the pointer/count FIFO. All state updates on posedge clk.
// TESTING
//   1. Reset: rstn=0 mid-run with count=2 -> mem_valid=0 and count=0 asynchronously; first push after release is the head.
//   2. Fill/stall: data_ready_mem=0, push 0x11 then 0x22 -> count=2, ex_stall=1 for a 3rd op; then pop -> head=0x11, next 0x22.
//   3. Simultaneous: count=1 (0xA), push 0xB with data_ready_mem=1 -> count stays 1, head=0xB on the next cycle.
//   4. FPU wait: ex_valid=1, alu_ready=0 for 5 cycles -> ex_stall=1 and no push; alu_ready=1 -> one push of the result.
//   5. Flush: count=2, flush=1 with ex_valid=1 and data_ready_mem=1 -> count=0, mem_valid=0, no entry written.
//   6. Wrap: DEPTH=2, stream of 8 results 1..8 with data_ready_mem toggling -> MEM sees 1..8 in order, no loss or duplicate.

Source files
------------

// File: rtl/ex_mem_buffer.sv
// ---------------------------------------------------------------------------
// ex_mem_buffer
//   EX->MEM pipeline buffer. This is a small in-order FIFO that sits directly
//   behind the ALU/FPU stage.
//   - It captures each completed EX result.
//   - It presents those results to MEM in the order they arrived.
//   - It stalls EX when full, so that long FPU operations and slow memory
//     accesses can overlap without dropping any result.
//
// Ports
//   clk, rstn          clock (rising edge), async active-low reset
//   ex_valid           EX holds an instruction this cycle
//   alu_ready          ALU/FPU result is final
//   alu_result_ex      result value
//   branch_alu         branch condition flag
//   write_data_ex      store data
//   rd_ex              destination register
//   reg_write_ex       register-file write enable
//   mem_read_ex        load
//   mem_write_ex       store
//   flush              discard every buffered entry
//   data_ready_mem     MEM consumes the head entry this cycle
//   ex_stall           EX must hold its instruction
//   mem_valid          head entry valid
//   *_mem              head entry fields (control fields qualified by mem_valid)
//   count              occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ex_mem_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       ex_valid,
  input  logic                       alu_ready,
  input  logic [XLEN-1:0]            alu_result_ex,
  input  logic                       branch_alu,
  input  logic [XLEN-1:0]            write_data_ex,
  input  logic [4:0]                 rd_ex,
  input  logic                       reg_write_ex,
  input  logic                       mem_read_ex,
  input  logic                       mem_write_ex,
  input  logic                       flush,
  input  logic                       data_ready_mem,
  output logic                       ex_stall,
  output logic                       mem_valid,
  output logic [XLEN-1:0]            alu_result_mem,
  output logic                       branch_mem,
  output logic [XLEN-1:0]            write_data_mem,
  output logic [4:0]                 rd_mem,
  output logic                       reg_write_mem,
  output logic                       mem_read_mem,
  output logic                       mem_write_mem,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] r_result [DEPTH];
  logic            r_branch [DEPTH];
  logic [XLEN-1:0] r_wdata  [DEPTH];
  logic [4:0]      r_rd     [DEPTH];
  logic            r_rw     [DEPTH];
  logic            r_mr     [DEPTH];
  logic            r_mw     [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // The push decision deliberately ignores data_ready_mem. A full buffer
  // refuses a push even when MEM pops in the same cycle, which keeps any
  // combinational path from MEM back into EX out of the design.
  assign w_push = ex_valid & alu_ready & ~w_full & ~flush;
  assign w_pop  = ~w_empty & data_ready_mem & ~flush;

  assign ex_stall = ex_valid & (~alu_ready | w_full | flush);

  // Pointers are PW bits wide; DEPTH is a power of two, so they wrap on
  // their own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage is not reset. Stale contents can never be seen, because
  // the head outputs only count while mem_valid is high.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_result[r_wr_ptr] <= alu_result_ex;
      r_branch[r_wr_ptr] <= branch_alu;
      r_wdata[r_wr_ptr]  <= write_data_ex;
      r_rd[r_wr_ptr]     <= rd_ex;
      r_rw[r_wr_ptr]     <= reg_write_ex;
      r_mr[r_wr_ptr]     <= mem_read_ex;
      r_mw[r_wr_ptr]     <= mem_write_ex;
    end
  end

  assign mem_valid      = ~w_empty;
  assign alu_result_mem = r_result[r_rd_ptr];
  assign branch_mem     = r_branch[r_rd_ptr];
  assign write_data_mem = r_wdata[r_rd_ptr];
  assign rd_mem         = r_rd[r_rd_ptr];
  assign reg_write_mem  = r_rw[r_rd_ptr] & ~w_empty;
  assign mem_read_mem   = r_mr[r_rd_ptr] & ~w_empty;
  assign mem_write_mem  = r_mw[r_rd_ptr] & ~w_empty;
  assign count          = r_count;

endmodule

// File: tb/tb_ex_mem_buffer.sv
module tb_ex_mem_buffer;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, alu_ready, branch_alu, reg_write_ex, mem_read_ex, mem_write_ex;
  logic        flush, data_ready_mem;
  logic [31:0] alu_result_ex, write_data_ex;
  logic [4:0]  rd_ex;
  logic        ex_stall, mem_valid, branch_mem, reg_write_mem, mem_read_mem, mem_write_mem;
  logic [31:0] alu_result_mem, write_data_mem;
  logic [4:0]  rd_mem;
  logic [1:0]  count;

  ent_t q[$];
  ent_t cur;
  int checks = 0;
  int errors = 0;

  ex_mem_buffer #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .alu_ready(alu_ready),
    .alu_result_ex(alu_result_ex), .branch_alu(branch_alu), .write_data_ex(write_data_ex),
    .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .mem_write_ex(mem_write_ex), .flush(flush), .data_ready_mem(data_ready_mem),
    .ex_stall(ex_stall), .mem_valid(mem_valid), .alu_result_mem(alu_result_mem),
    .branch_mem(branch_mem), .write_data_mem(write_data_mem), .rd_mem(rd_mem),
    .reg_write_mem(reg_write_mem), .mem_read_mem(mem_read_mem),
    .mem_write_mem(mem_write_mem), .count(count)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [31:0] r);
    ent_t e;
    e.res = r;
    e.br  = 1'($urandom);
    e.wd  = $urandom;
    e.rd  = 5'($urandom);
    e.rw  = 1'($urandom);
    e.mr  = 1'($urandom);
    e.mw  = 1'($urandom);
    return e;
  endfunction

  task automatic drive(input logic v, input logic ar, input ent_t e, input logic fl, input logic dr);
    ex_valid = v; alu_ready = ar; flush = fl; data_ready_mem = dr;
    alu_result_ex = e.res; branch_alu = e.br; write_data_ex = e.wd; rd_ex = e.rd;
    reg_write_ex = e.rw; mem_read_ex = e.mr; mem_write_ex = e.mw;
    cur = e;
  endtask

  // Advance one clock and update the queue model from the rules:
  // a flush empties it; otherwise an accepted pop removes the head and an
  // accepted push (only when not full) appends the driven entry.
  task automatic tick();
    bit push, pop;
    @(posedge clk);
    push = ex_valid && alu_ready && (q.size() < 2) && !flush;
    pop  = (q.size() > 0) && data_ready_mem && !flush;
    if (!rstn || flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(cur);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 1'b0, mk(32'h0), 1'b0, dr);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(1'b0);
    #2;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({reg_write_mem, mem_read_mem, mem_write_mem} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {reg_write_mem, mem_read_mem, mem_write_mem}); end
    @(negedge clk);
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill_stall();
    drive(1'b1, 1'b1, mk(32'h11), 1'b0, 1'b0); #1;
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL fill_stall_empty got %b exp 0", ex_stall); end
    tick();
    drive(1'b1, 1'b1, mk(32'h22), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, mk(32'h33), 1'b0, 1'b0); #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_count got %0d exp 2", count); end
    checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL fill_stall_full got %b exp 1", ex_stall); end
    tick();
    idle(1'b1); #1;
    checks++; if (alu_result_mem !== 32'h11) begin errors++; $display("FAIL fill_head1 got %h exp 11", alu_result_mem); end
    tick(); #1;
    checks++; if (alu_result_mem !== 32'h22 || count !== 2'd1) begin
      errors++; $display("FAIL fill_head2 got %h/%0d exp 22/1", alu_result_mem, count); end
    tick(); #1;
    checks++; if (mem_valid !== 1'b0 || count !== 2'd0) begin
      errors++; $display("FAIL fill_drain got %b/%0d exp 0/0", mem_valid, count); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, mk(32'hA1), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, mk(32'hA2), 1'b0, 1'b0); tick();
    idle(1'b0); #2;
    rstn = 1'b0; #1;
    q.delete();
    checks++; if (mem_valid !== 1'b0 || count !== 2'd0) begin
      errors++; $display("FAIL midreset_async got %b/%0d exp 0/0", mem_valid, count); end
    checks++; if ({reg_write_mem, mem_read_mem, mem_write_mem} !== 3'b000) begin
      errors++; $display("FAIL midreset_ctrl got %b exp 000", {reg_write_mem, mem_read_mem, mem_write_mem}); end
    @(negedge clk);
    tick();
    rstn = 1'b1;
    drive(1'b1, 1'b1, mk(32'h55), 1'b0, 1'b0); tick();
    idle(1'b0); #1;
    checks++; if (alu_result_mem !== 32'h55 || count !== 2'd1) begin
      errors++; $display("FAIL midreset_head got %h/%0d exp 55/1", alu_result_mem, count); end
    idle(1'b1); tick();
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b1, mk(32'hA), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, mk(32'hB), 1'b0, 1'b1); #1;
    checks++; if (alu_result_mem !== 32'hA || count !== 2'd1) begin
      errors++; $display("FAIL simul_before got %h/%0d exp a/1", alu_result_mem, count); end
    tick();
    idle(1'b0); #1;
    checks++; if (alu_result_mem !== 32'hB || count !== 2'd1) begin
      errors++; $display("FAIL simul_after got %h/%0d exp b/1", alu_result_mem, count); end
    idle(1'b1); tick();
  endtask

  task automatic test_fpu_wait();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, mk(32'h77), 1'b0, 1'b0); #1;
      checks++; if (ex_stall !== 1'b1 || count !== 2'd0) begin
        errors++; $display("FAIL fpu_wait%0d got %b/%0d exp 1/0", i, ex_stall, count); end
      tick();
    end
    drive(1'b1, 1'b1, mk(32'h77), 1'b0, 1'b0); #1;
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL fpu_ready_stall got %b exp 0", ex_stall); end
    tick();
    idle(1'b0); #1;
    checks++; if (count !== 2'd1 || alu_result_mem !== 32'h77) begin
      errors++; $display("FAIL fpu_push got %0d/%h exp 1/77", count, alu_result_mem); end
    idle(1'b1); tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, mk(32'h1), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, mk(32'h2), 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, mk(32'h3), 1'b1, 1'b1); #1;
    checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %b exp 1", ex_stall); end
    tick();
    idle(1'b0); #1;
    checks++; if (count !== 2'd0 || mem_valid !== 1'b0 || mem_write_mem !== 1'b0) begin
      errors++; $display("FAIL flush_empty got %0d/%b/%b exp 0/0/0", count, mem_valid, mem_write_mem); end
    drive(1'b1, 1'b1, mk(32'h9), 1'b0, 1'b0); tick();
    idle(1'b0); #1;
    checks++; if (count !== 2'd1 || alu_result_mem !== 32'h9) begin
      errors++; $display("FAIL flush_next got %0d/%h exp 1/9", count, alu_result_mem); end
    idle(1'b1); tick();
  endtask

  task automatic test_wrap();
    int nxt = 1;
    int exp_v = 1;
    int cyc = 0;
    while (exp_v <= 8 && cyc < 200) begin
      logic dr;
      logic v;
      dr = logic'(cyc % 2);
      v  = (nxt <= 8);
      drive(v, 1'b1, mk(32'(nxt)), 1'b0, dr); #1;
      if (mem_valid && dr) begin
        checks++; if (alu_result_mem !== 32'(exp_v)) begin
          errors++; $display("FAIL wrap_order got %0d exp %0d", alu_result_mem, exp_v); end
        exp_v++;
      end
      if (v && !ex_stall) nxt++;
      tick();
      cyc++;
    end
    checks++; if (exp_v != 9) begin errors++; $display("FAIL wrap_timeout got %0d exp 9", exp_v); end
    idle(1'b0); #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL wrap_final_count got %0d exp 0", count); end
  endtask

  task automatic test_random();
    q.delete();
    for (int i = 0; i < 400; i++) begin
      logic v, ar, fl, dr;
      logic est;
      v  = 1'($urandom);
      ar = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0);
      dr = 1'($urandom);
      drive(v, ar, mk($urandom), fl, dr); #1;
      est = v && (!ar || q.size() == 2 || fl);
      checks++; if (count !== 2'(q.size()) || mem_valid !== (q.size() != 0) || ex_stall !== est) begin
        errors++; $display("FAIL rand_state cyc %0d got cnt %0d v %b st %b exp cnt %0d v %b st %b",
          i, count, mem_valid, ex_stall, q.size(), (q.size() != 0), est); end
      if (q.size() != 0) begin
        checks++;
        if (alu_result_mem !== q[0].res || branch_mem !== q[0].br || write_data_mem !== q[0].wd ||
            rd_mem !== q[0].rd || reg_write_mem !== q[0].rw || mem_read_mem !== q[0].mr ||
            mem_write_mem !== q[0].mw) begin
          errors++; $display("FAIL rand_head cyc %0d got %h %b %h %0d %b%b%b exp %h %b %h %0d %b%b%b", i,
            alu_result_mem, branch_mem, write_data_mem, rd_mem, reg_write_mem, mem_read_mem, mem_write_mem,
            q[0].res, q[0].br, q[0].wd, q[0].rd, q[0].rw, q[0].mr, q[0].mw);
        end
      end else begin
        checks++;
        if ({reg_write_mem, mem_read_mem, mem_write_mem} !== 3'b000) begin
          errors++; $display("FAIL rand_empty_ctrl cyc %0d got %b exp 000", i,
            {reg_write_mem, mem_read_mem, mem_write_mem});
        end
      end
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle(1'b0);
    test_reset();
    test_fill_stall();
    test_reset_mid();
    test_simultaneous();
    test_fpu_wait();
    test_flush();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
